// File: rtl/register_writeback.sv
// register_writeback
// Writer-side front end for the general register file. Result traffic from
// the ALU and the load unit is arbitrated onto the file's single write port.
// The ALU normally has priority. A load that is stalled for STARVE_LIMIT
// consecutive cycles is forced through. A pending-write scoreboard tells the
// issue stage which registers still have an outstanding producer.
//
// Ports:
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   alu_valid/ready/dest/data  ALU result channel (valid/ready handshake)
//   ld_valid/ready/dest/data   load result channel (valid/ready handshake)
//   alloc_en, alloc_dest       issue stage reserves a destination register
//   pending                    one bit per register, 1 = outstanding write
//   err_realloc                one-cycle pulse: alloc hit an already-pending register
//   reg_write_en/dest/data     register file write port, one cycle after accept
//
// Optional feature, macro WB_STATS_EN:
//   adds wb_write_cnt (cycles with reg_write_en=1) and wb_stall_cnt (cycles
//   with an offered but refused result). Both are 16-bit, wrap, and are
//   cleared by rst.

module register_writeback #(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_dest,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [ADDR_W-1:0]    ld_dest,
    input  logic [DATA_W-1:0]    ld_data,
    input  logic                 alloc_en,
    input  logic [ADDR_W-1:0]    alloc_dest,
    output logic [(1<<ADDR_W)-1:0] pending,
    output logic                 err_realloc,
    output logic                 reg_write_en,
    output logic [ADDR_W-1:0]    reg_write_dest,
    output logic [DATA_W-1:0]    reg_write_data
`ifdef WB_STATS_EN
    ,
    output logic [15:0]          wb_write_cnt,
    output logic [15:0]          wb_stall_cnt
`endif
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic                starve_q, starve_unused;
    logic [3:0]          starveCnt_q, starveCnt_d;
    logic                writeEn_q, writeEn_d;
    logic [ADDR_W-1:0]   writeDest_q, writeDest_d;
    logic [DATA_W-1:0]   writeData_q, writeData_d;
    logic [NREG-1:0]     pending_q, pending_d;
    logic                errRealloc_q, errRealloc_d;

    logic                forceLoad;
    logic                aluAccept;
    logic                ldAccept;
    logic [NREG-1:0]     clearMask;

    assign starve_q      = 1'b0;
    assign starve_unused = starve_q;

    // The load channel wins outright once it has waited STARVE_LIMIT cycles.
    // Neither ready looks at its own channel's valid, and the two accepts are
    // mutually exclusive by construction.
    assign forceLoad = (starveCnt_q == LIMIT);
    assign alu_ready = !rst && !forceLoad;
    assign ld_ready  = !rst && (forceLoad || !alu_valid);
    assign aluAccept = alu_valid && alu_ready;
    assign ldAccept  = ld_valid && ld_ready;

    // Next-state for the write port, starve counter and scoreboard.
    // A scoreboard bit is cleared by the accepted transfer at the accept edge,
    // and a same-edge alloc of that register sets it again (new producer wins).
    always_comb begin
        writeEn_d    = aluAccept || ldAccept;
        writeDest_d  = writeDest_q;
        writeData_d  = writeData_q;
        clearMask    = '0;
        if (aluAccept) begin
            writeDest_d          = alu_dest;
            writeData_d          = alu_data;
            clearMask[alu_dest]  = 1'b1;
        end else if (ldAccept) begin
            writeDest_d          = ld_dest;
            writeData_d          = ld_data;
            clearMask[ld_dest]   = 1'b1;
        end

        starveCnt_d = starveCnt_q;
        if (ldAccept) begin
            starveCnt_d = '0;
        end else if (ld_valid && (starveCnt_q != LIMIT)) begin
            starveCnt_d = starveCnt_q + 4'd1;
        end

        errRealloc_d = alloc_en && pending_q[alloc_dest] && !clearMask[alloc_dest];
        pending_d    = pending_q & ~clearMask;
        if (alloc_en) begin
            pending_d[alloc_dest] = 1'b1;
        end
    end

    // State registers. Reset also drops an accepted-but-unwritten result.
    always_ff @(posedge clk) begin
        if (rst) begin
            writeEn_q    <= 1'b0;
            writeDest_q  <= '0;
            writeData_q  <= '0;
            pending_q    <= '0;
            errRealloc_q <= 1'b0;
            starveCnt_q  <= '0;
        end else begin
            writeEn_q    <= writeEn_d;
            writeDest_q  <= writeDest_d;
            writeData_q  <= writeData_d;
            pending_q    <= pending_d;
            errRealloc_q <= errRealloc_d;
            starveCnt_q  <= starveCnt_d;
        end
    end

    assign reg_write_en   = writeEn_q;
    assign reg_write_dest = writeDest_q;
    assign reg_write_data = writeData_q;
    assign pending        = pending_q;
    assign err_realloc    = errRealloc_q;

`ifdef WB_STATS_EN
    logic [15:0] writeCnt_q;
    logic [15:0] stallCnt_q;
    logic        stallNow;

    assign stallNow = (alu_valid && !alu_ready) || (ld_valid && !ld_ready);

    // Activity counters, free-running and wrapping modulo 2^16.
    always_ff @(posedge clk) begin
        if (rst) begin
            writeCnt_q <= '0;
            stallCnt_q <= '0;
        end else begin
            if (writeEn_q) begin
                writeCnt_q <= writeCnt_q + 16'd1;
            end
            if (stallNow) begin
                stallCnt_q <= stallCnt_q + 16'd1;
            end
        end
    end

    assign wb_write_cnt = writeCnt_q;
    assign wb_stall_cnt = stallCnt_q;
`endif

endmodule

// File: doc/register_writeback.md
Name: register_writeback

Overview:
Writer-side front end for the 8x16 general register file. It arbitrates result traffic from the ALU and the load unit onto the file's single write port (write enable, 3-bit destination, 16-bit data). It guarantees the load unit forward progress with a starvation limit. It keeps a pending-write scoreboard for the issue stage.

Parameters:
STARVE_LIMIT, 4, consecutive stalled cycles of a valid load before the load channel is forced to win (1..15)
DATA_W, 16, register data width (matches the register file)
ADDR_W, 3, register address width (8 registers)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted this cycle when valid&ready
alu_dest  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
ld_valid  in  1  load result offered
ld_ready  out  1  load result accepted this cycle when valid&ready
ld_dest  in  ADDR_W  load destination register
ld_data  in  DATA_W  load data
alloc_en  in  1  issue stage reserves a destination
alloc_dest  in  ADDR_W  reserved register
pending  out  8  bit r=1: register r has an outstanding write
err_realloc  out  1  one-cycle pulse: alloc to an already-pending register
reg_write_en  out  1  register file write enable
reg_write_dest  out  ADDR_W  register file write address
reg_write_data  out  DATA_W  register file write data

Behaviour:
- Reset (rst=1 at a clock edge): reg_write_en=0, reg_write_dest=0, reg_write_data=0, pending=8'h00, err_realloc=0, starve counter=0. While rst=1, alu_ready=0 and ld_ready=0 combinationally.
- Arbitration is combinational from the current inputs and the starve counter:
  - force = (starve_cnt == STARVE_LIMIT).
  - force=0: alu_ready=1; ld_ready = !alu_valid (ALU has priority).
  - force=1: ld_ready=1; alu_ready=0.
  - At most one channel is accepted per cycle.
  - ready never depends on its own channel's valid.
- Starve counter:
  - At each edge, if ld_valid & !ld_ready: increment, saturating at STARVE_LIMIT.
  - If a load is accepted: clear to 0.
  - If ld_valid=0: hold the value (no decay).
- Write port:
  - A transfer accepted at edge N drives reg_write_en=1 with that dest/data for exactly the cycle following edge N. Latency is 1 cycle.
  - With no transfer, reg_write_en=0. dest/data hold their last value.
  - Back-to-back accepts produce back-to-back write cycles. There are no bubbles and no internal buffering beyond this one output register.
- Scoreboard:
  - At each edge, a bit is cleared for the accepted transfer's dest (clear happens at the accept edge).
  - A bit is set for alloc_dest when alloc_en=1.
  - Set and clear of the same register on the same edge: set wins (new producer).
  - Alloc to a bit already 1 and not being cleared that edge: bit stays 1; err_realloc=1 for the next cycle only.
  - Writes to non-pending registers are legal and leave the bit at 0.
- Reset mid-operation: any accepted-but-unwritten result is dropped (reg_write_en forced 0 next cycle). Upstream must re-present it after reset.
- Inputs offered with valid=1 and ready=0 must be held stable by the sender. The block does not check this.

Optional Feature:
WB_STATS_EN
- Defined: adds outputs wb_write_cnt[15:0] (increments on every cycle with reg_write_en=1) and wb_stall_cnt[15:0] (increments on every cycle with (alu_valid&!alu_ready)|(ld_valid&!ld_ready)). Both wrap modulo 2^16 and are cleared by rst.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset: drive rst=1 for 2 cycles with both valids=1 -> readies 0, reg_write_en=0, pending=00. Release rst, ALU offers r3=16'h1234 -> next cycle reg_write_en=1, dest=3, data=1234.
- Priority: alu_valid and ld_valid both 1 for one cycle (alu r1=AAAA, ld r2=5555) -> ALU accepted first, load accepted the following cycle. Writes appear on consecutive cycles in order r1 then r2.
- Starvation: alu_valid held 1 continuously, ld_valid=1 (r6=0F0F), STARVE_LIMIT=4 -> ld_ready=0 for 4 cycles, ld_ready=1/alu_ready=0 on the 5th cycle. r6 is written the next cycle, then the counter returns to 0 and ALU regains priority.
- Scoreboard: alloc r5 -> pending=8'h20. ALU result to r5 accepted while alloc r5 occurs on the same edge -> pending stays 8'h20, err_realloc=0. Alloc r5 again with no write -> err_realloc pulses 1 for one cycle.
- Reset mid-op: accept load r7=BEEF at edge N with rst=1 at edge N+1 -> reg_write_en=0 after edge N+1, pending=00.
- With WB_STATS_EN: 3 writes plus 4 stall cycles -> wb_write_cnt=3, wb_stall_cnt=4. Preload wb_write_cnt=FFFF and perform one write -> wb_write_cnt wraps to 0000.
